cpu_control_fsm: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 36 +++
 rtl/alu_decoder.sv | 43 ++++
 rtl/cpu_control_fsm.sv | 163 ++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control sequencer:
// FSM states, opcode/funct fields and the 4-bit ALU control codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct to ALU control decode; valid is low for any
// opcode or R-type funct the datapath does not support (including HALT).
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output logic [3:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_AND;
    valid  = 1'b0;
    case (op)
      OP_RTYPE: begin
        valid = 1'b1;
        case (fn)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: valid  = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        valid  = 1'b1;
      end
      default: begin
        alu_op = ALU_AND;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with run/step/halt
// control and a retired-instruction counter. All outputs are Moore.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [5:0]       instr_op,
  input  logic [5:0]       funct,
  output logic             reg_dst,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_to_reg,
  output logic [3:0]       alu_op,
  output logic             mem_write,
  output logic             alu_src,
  output logic             reg_write,
  output logic             pc_write,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_reg, state_next;
  logic [5:0]       op_q_reg, op_q_next;
  logic [5:0]       fn_q_reg, fn_q_next;
  logic             single_reg, single_next;
  logic             illegal_reg, illegal_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [3:0] alu_q;
  logic       valid_q;
  logic [3:0] alu_in_unused;
  logic       valid_in;

  logic is_r, is_lw, is_sw, is_beq, is_addi;
  logic in_body, is_last;

  // Output decode works from the latched fields only, keeping outputs Moore.
  alu_decoder u_dec_q (
    .op     (op_q_reg),
    .fn     (fn_q_reg),
    .alu_op (alu_q),
    .valid  (valid_q)
  );

  // Second copy looks at the live fields so DECODE can branch on legality.
  alu_decoder u_dec_in (
    .op     (instr_op),
    .fn     (funct),
    .alu_op (alu_in_unused),
    .valid  (valid_in)
  );

  assign is_r    = (op_q_reg == OP_RTYPE);
  assign is_lw   = (op_q_reg == OP_LW);
  assign is_sw   = (op_q_reg == OP_SW);
  assign is_beq  = (op_q_reg == OP_BEQ);
  assign is_addi = (op_q_reg == OP_ADDI);

  assign in_body = (state_reg == ST_EXEC) || (state_reg == ST_MEM) || (state_reg == ST_WB);
  assign is_last = ((state_reg == ST_EXEC) && is_beq) ||
                   ((state_reg == ST_MEM)  && is_sw)  ||
                   (state_reg == ST_WB);

  always_comb begin
    state_next   = state_reg;
    op_q_next    = op_q_reg;
    fn_q_next    = fn_q_reg;
    single_next  = single_reg;
    illegal_next = illegal_reg;
    count_next   = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (run) begin
          state_next  = ST_FETCH;
          single_next = 1'b0;
        end else if (step) begin
          state_next  = ST_FETCH;
          single_next = 1'b1;
        end
      end
      ST_FETCH: state_next = ST_DECODE;
      ST_DECODE: begin
        op_q_next = instr_op;
        fn_q_next = funct;
        if (instr_op == OP_HALT) begin
          state_next = ST_HALT;
        end else if (!valid_in) begin
          illegal_next = 1'b1;
          state_next   = ST_HALT;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC, ST_MEM, ST_WB: begin
        if (is_last) begin
          count_next  = count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
          single_next = 1'b0;
          state_next  = (run && !single_reg) ? ST_FETCH : ST_IDLE;
        end else if (state_reg == ST_EXEC) begin
          state_next = (is_lw || is_sw) ? ST_MEM : ST_WB;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    reg_dst    = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 4'b0000;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    if (in_body && valid_q) begin
      alu_op     = alu_q;
      alu_src    = is_lw || is_sw || is_addi;
      branch     = (state_reg == ST_EXEC) && is_beq;
      mem_read   = is_lw && ((state_reg == ST_MEM) || (state_reg == ST_WB));
      mem_write  = is_sw && (state_reg == ST_MEM);
      reg_write  = (state_reg == ST_WB);
      reg_dst    = (state_reg == ST_WB) && is_r;
      mem_to_reg = (state_reg == ST_WB) && is_lw;
      pc_write   = is_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      op_q_reg    <= '0;
      fn_q_reg    <= '0;
      single_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      op_q_reg    <= op_q_next;
      fn_q_reg    <= fn_q_next;
      single_reg  <= single_next;
      illegal_reg <= illegal_next;
      count_reg   <= count_next;
    end
  end

  assign state       = state_reg;
  assign halted      = (state_reg == ST_IDLE) || (state_reg == ST_HALT);
  assign illegal     = illegal_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed scenarios plus a random
// instruction stream compared against a per-class phase/strobe model.
module tb_cpu_control_fsm;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic step = 1'b0;
  logic [5:0] instr_op = 6'h00;
  logic [5:0] funct = 6'h00;
  logic reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, pc_write;
  logic [3:0] alu_op;
  logic [2:0] state;
  logic halted, illegal;
  logic [CNT_W-1:0] instr_count;

  int n_checks = 0;
  int n_fails = 0;

  logic [14:0] obs;
  assign obs = {state, reg_dst, branch, mem_read, mem_to_reg, alu_op,
                mem_write, alu_src, reg_write, pc_write};

  cpu_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .instr_op(instr_op), .funct(funct),
    .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read),
    .mem_to_reg(mem_to_reg), .alu_op(alu_op), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .pc_write(pc_write),
    .state(state), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Instruction classes: 0..5 R-type (add,sub,and,or,nor,slt), 6 lw, 7 sw, 8 beq, 9 addi.
  logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
  logic [3:0] alu_tab[6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

  function automatic int n_body(int cls);
    if (cls == 6) return 3;
    if (cls == 8) return 1;
    return 2;
  endfunction

  function automatic int body_st(int cls, int k);
    if (cls == 6 || cls == 7) return 3 + k;
    if (cls == 8) return 3;
    return (k == 0) ? 3 : 5;
  endfunction

  function automatic logic [5:0] op_of(int cls);
    case (cls)
      6: return 6'h23;
      7: return 6'h2B;
      8: return 6'h04;
      9: return 6'h08;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [14:0] exp_vec(int cls, int st, bit last);
    logic [3:0] a;
    bit r, lw, sw, bq, ad, body;
    r = (cls < 6); lw = (cls == 6); sw = (cls == 7); bq = (cls == 8); ad = (cls == 9);
    a = 4'b0010;
    if (r) a = alu_tab[cls];
    else if (bq) a = 4'b0110;
    body = (st >= 3 && st <= 5);
    return {3'(st), body && st == 5 && r, st == 3 && bq, lw && (st == 4 || st == 5),
            lw && st == 5, body ? a : 4'b0000, sw && st == 4, body && (lw || sw || ad),
            st == 5, last};
  endfunction

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== 15'd0) begin
      n_fails++; $display("FAIL reset_outputs: got %h expected %h", obs, 15'd0);
    end
    n_checks++;
    if ({halted, illegal, instr_count} !== {1'b1, 1'b0, 4'd0}) begin
      n_fails++; $display("FAIL reset_status: halted=%b illegal=%b count=%0d, expected 1 0 0",
                          halted, illegal, instr_count);
    end
    $display("reset: state=%0d halted=%b count=%0d", state, halted, instr_count);
    rst = 1'b0;
  endtask

  task automatic test_rtype_add();
    logic [14:0] exp[4];
    exp[0] = {3'd1, 12'd0};
    exp[1] = {3'd2, 12'd0};
    exp[2] = {3'd3, 4'b0000, 4'b0010, 4'b0000};
    exp[3] = {3'd5, 4'b1000, 4'b0010, 4'b0011};
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    run = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp[c]) begin
        n_fails++; $display("FAIL rtype_add cyc %0d: got %h expected %h", c, obs, exp[c]);
      end
      if (c == 1) begin instr_op = 6'h00; funct = 6'h20; end
      else begin instr_op = 6'h3F; funct = 6'h03; end
      if (c == 3) run = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({state, halted, instr_count} !== {3'd0, 1'b1, 4'd1}) begin
      n_fails++; $display("FAIL rtype_add_end: state=%0d halted=%b count=%0d expected 0 1 1",
                          state, halted, instr_count);
    end
    $display("rtype add: final state=%0d count=%0d", state, instr_count);
  endtask

  task automatic test_random_stream(int n);
    logic [CNT_W-1:0] cnt_m;
    int cls, nb, st;
    bit last;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    cnt_m = '0;
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      cls = $urandom_range(0, 9);
      nb = n_body(cls);
      for (int c = 0; c < nb + 2; c++) begin
        st = (c == 0) ? 1 : (c == 1) ? 2 : body_st(cls, c - 2);
        last = (c == nb + 1);
        @(negedge clk);
        n_checks++;
        if (obs !== exp_vec(cls, st, last)) begin
          n_fails++; $display("FAIL stream instr %0d cls %0d cyc %0d: got %h expected %h",
                              i, cls, c, obs, exp_vec(cls, st, last));
        end
        n_checks++;
        if (instr_count !== cnt_m) begin
          n_fails++; $display("FAIL stream_count instr %0d: got %0d expected %0d", i, instr_count, cnt_m);
        end
        if (c == 1) begin
          instr_op = op_of(cls);
          funct = (cls < 6) ? fn_tab[cls] : 6'($urandom);
        end else begin
          instr_op = 6'($urandom);
          funct = 6'($urandom);
        end
        step = 1'($urandom);
        if (last) cnt_m = cnt_m + 1'b1;
      end
      $display("stream instr %0d: class %0d count_model=%0d", i, cls, cnt_m);
    end
    step = 1'b0;
  endtask

  task automatic test_run_drop();
    logic [14:0] exp[5];
    exp[0] = exp_vec(6, 1, 0);
    exp[1] = exp_vec(6, 2, 0);
    exp[2] = exp_vec(6, 3, 0);
    exp[3] = exp_vec(6, 4, 0);
    exp[4] = exp_vec(6, 5, 1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp[c]) begin
        n_fails++; $display("FAIL run_drop cyc %0d: got %h expected %h", c, obs, exp[c]);
      end
      instr_op = (c == 1) ? 6'h23 : 6'h2B;
      if (c == 2) run = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({state, instr_count} !== {3'd0, 4'd1}) begin
      n_fails++; $display("FAIL run_drop_end: state=%0d count=%0d expected 0 1", state, instr_count);
    end
    $display("run drop lw: final state=%0d count=%0d", state, instr_count);
  endtask

  task automatic test_single_step();
    int mw = 0;
    int pw = 0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    run = 1'b0; instr_op = 6'h2B; funct = 6'h00;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      mw += int'(mem_write);
      pw += int'(pc_write);
      step = (c == 4);
      @(negedge clk);
    end
    n_checks++;
    if (mw !== 1 || pw !== 1) begin
      n_fails++; $display("FAIL single_step_strobes: mem_write cycles=%0d pc_write cycles=%0d expected 1 1", mw, pw);
    end
    n_checks++;
    if ({state, halted, instr_count} !== {3'd0, 1'b1, 4'd1}) begin
      n_fails++; $display("FAIL single_step_end: state=%0d halted=%b count=%0d expected 0 1 1",
                          state, halted, instr_count);
    end
    $display("single step sw: mem_write cycles=%0d count=%0d", mw, instr_count);
  endtask

  task automatic test_halt_illegal();
    logic [5:0] ops[3] = '{6'h3F, 6'h11, 6'h00};
    logic [5:0] fns[3] = '{6'h20, 6'h20, 6'h03};
    logic       ill[3] = '{1'b0, 1'b1, 1'b1};
    int pw;
    for (int k = 0; k < 3; k++) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      run = 1'b1; pw = 0;
      @(negedge clk);
      @(negedge clk);
      instr_op = ops[k]; funct = fns[k];
      n_checks++;
      if ({state, illegal} !== {3'd2, 1'b0}) begin
        n_fails++; $display("FAIL halt_decode case %0d: state=%0d illegal=%b expected 2 0", k, state, illegal);
      end
      @(negedge clk);
      instr_op = 6'h00; funct = 6'h20;
      n_checks++;
      if ({state, halted, illegal} !== {3'd6, 1'b1, ill[k]}) begin
        n_fails++; $display("FAIL halt_entry case %0d: state=%0d halted=%b illegal=%b expected 6 1 %b",
                            k, state, halted, illegal, ill[k]);
      end
      for (int c = 0; c < 6; c++) begin
        pw += int'(pc_write) + int'(obs[11:1] != 11'd0);
        @(negedge clk);
      end
      n_checks++;
      if ({state, illegal, instr_count} !== {3'd6, ill[k], 4'd0} || pw !== 0) begin
        n_fails++; $display("FAIL halt_hold case %0d: state=%0d illegal=%b count=%0d strobes=%0d expected 6 %b 0 0",
                            k, state, illegal, instr_count, pw, ill[k]);
      end
      $display("halt case op=%h fn=%h: state=%0d illegal=%b", ops[k], fns[k], state, illegal);
    end
    run = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    int guard = 0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    instr_op = 6'h00; funct = 6'h20; run = 1'b1;
    while (instr_count !== 4'd7 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (instr_count !== 4'd7) begin
      n_fails++; $display("FAIL mid_mem_setup: count=%0d expected 7 within 100 cycles", instr_count);
    end
    instr_op = 6'h2B;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({state, mem_write, instr_count} !== {3'd4, 1'b1, 4'd7}) begin
      n_fails++; $display("FAIL mid_mem_before: state=%0d mem_write=%b count=%0d expected 4 1 7",
                          state, mem_write, instr_count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({obs, halted, illegal, instr_count} !== {15'd0, 1'b1, 1'b0, 4'd0}) begin
      n_fails++; $display("FAIL mid_mem_reset: obs=%h halted=%b illegal=%b count=%0d expected 0 1 0 0",
                          obs, halted, illegal, instr_count);
    end
    $display("reset mid MEM: state=%0d mem_write=%b count=%0d", state, mem_write, instr_count);
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_random_stream(40);
    test_run_drop();
    test_single_step();
    test_halt_illegal();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
